// File: rtl/arith_pkg.sv
// Shared encodings and sizing helpers for the digit-serial arithmetic blocks.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of digit steps needed for one operation.
   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width; at least one bit so a single-digit build still elaborates.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple adder for one digit; also exposes the carry into its top bit.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   // One full adder per bit, carries chained LSB to MSB.
   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign cout = c[DIGIT];
   assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// valid/ready on both sides, reports raw carry out and signed overflow.
module serial_add_sub
   import arith_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int NDIG = ndig(WIDTH, DIGIT);
   localparam int CW   = cnt_w(NDIG);

   if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
   end

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_r;
   logic [WIDTH-1:0] a_nxt, b_nxt, sum_nxt;
   logic             c_r, co_r, ov_r;
   logic [CW-1:0]    cnt;
   logic             last;
   logic [DIGIT-1:0] d_s;
   logic             d_co, d_cmsb;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .cin  (c_r),
      .s    (d_s),
      .cout (d_co),
      .cmsb (d_cmsb)
   );

   assign last      = (cnt == CW'(NDIG - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_r;
   assign carry_out = co_r;
   assign overflow  = ov_r;

   // Shift helpers: operands move right a digit, result digits enter from the MSB side.
   // Widening by one digit keeps the slices valid when DIGIT == WIDTH.
   always_comb begin
      logic [WIDTH+DIGIT-1:0] a_ext, b_ext, s_ext;
      a_ext   = {{DIGIT{1'b0}}, a_sh};
      b_ext   = {{DIGIT{1'b0}}, b_sh};
      s_ext   = {d_s, sum_r};
      a_nxt   = a_ext[WIDTH+DIGIT-1:DIGIT];
      b_nxt   = b_ext[WIDTH+DIGIT-1:DIGIT];
      sum_nxt = s_ext[WIDTH+DIGIT-1:DIGIT];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last)     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture in IDLE, one digit per cycle in RUN, results held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         sum_r <= '0;
         c_r   <= 1'b0;
         cnt   <= '0;
         co_r  <= 1'b0;
         ov_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtract as a + ~b + 1; borrow-in folds into the inverted carry.
                  a_sh <= a;
                  b_sh <= sub ? ~b : b;
                  c_r  <= sub ? ~carry_in : carry_in;
                  cnt  <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_nxt;
               b_sh  <= b_nxt;
               sum_r <= sum_nxt;
               c_r   <= d_co;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  co_r <= d_co;
                  ov_r <= d_cmsb ^ d_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
